// File: rtl/mux_2x1_nbit_stream.sv
// mux_2x1_nbit_stream
//   Merges two valid/ready input streams (w0, w1) into one output stream
//   (f) held in a single-entry output register. The source tag s marks the
//   channel each word came from (0 = w0, 1 = w1). Latency is one clock, and
//   the block sustains one word per clock.
//
//   Configuration macro: MUX_RR_ARB_EN
//     defined   -> round-robin arbitration between w0 and w1
//     undefined -> fixed priority, w0 wins contention
//
//   Ports
//     clk       in   rising-edge clock
//     reset     in   asynchronous active-high reset
//     w0        in   [N] channel-0 data
//     w0_valid  in   w0 holds a word
//     w0_ready  out  block accepts w0 this cycle
//     w1        in   [N] channel-1 data
//     w1_valid  in   w1 holds a word
//     w1_ready  out  block accepts w1 this cycle
//     f         out  [N] merged output data
//     s         out  source tag of f
//     f_valid   out  f and s hold a word
//     f_ready   in   sink accepts f this cycle
module mux_2x1_nbit_stream #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] w0,
  input  logic         w0_valid,
  output logic         w0_ready,
  input  logic [N-1:0] w1,
  input  logic         w1_valid,
  output logic         w1_ready,
  output logic [N-1:0] f,
  output logic         s,
  output logic         f_valid,
  input  logic         f_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   f_q, f_d;
  logic           s_q, s_d;
  logic           can_load;
  logic           pick_w1;
  logic           in_xfer;
  logic           out_xfer;

`ifdef MUX_RR_ARB_EN
  // Channel granted most recently; resets to 1 so w0 wins first contention.
  logic           last_q, last_d;
`endif

  always_comb begin
    can_load = (state_q == EMPTY) || f_ready;

`ifdef MUX_RR_ARB_EN
    // Under contention, take w1 only if w0 was granted last.
    pick_w1 = w1_valid && (!w0_valid || !last_q);
`else
    pick_w1 = w1_valid && !w0_valid;
`endif

    // Readies are held low during reset so no transfer can be seen then.
    w1_ready = !reset && can_load && pick_w1;
    w0_ready = !reset && can_load && w0_valid && !pick_w1;

    in_xfer  = w0_ready || w1_ready;
    out_xfer = (state_q == FULL) && f_ready;

    state_d = state_q;
    f_d     = f_q;
    s_d     = s_q;
`ifdef MUX_RR_ARB_EN
    last_d  = last_q;
`endif

    if (in_xfer) begin
      f_d     = pick_w1 ? w1 : w0;
      s_d     = pick_w1;
      state_d = FULL;
`ifdef MUX_RR_ARB_EN
      last_d  = pick_w1;
`endif
    end else if (out_xfer) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      f_q     <= '0;
      s_q     <= 1'b0;
`ifdef MUX_RR_ARB_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      f_q     <= f_d;
      s_q     <= s_d;
`ifdef MUX_RR_ARB_EN
      last_q  <= last_d;
`endif
    end
  end

  assign f       = f_q;
  assign s       = s_q;
  assign f_valid = (state_q == FULL);

endmodule

// File: tb/tb_mux_2x1_nbit_stream.sv
module tb_mux_2x1_nbit_stream;

  localparam int unsigned N = 4;

  logic         clk;
  logic         reset;
  logic [N-1:0] w0, w1;
  logic         w0_valid, w1_valid;
  logic         w0_ready, w1_ready;
  logic [N-1:0] f;
  logic         s;
  logic         f_valid;
  logic         f_ready;

  mux_2x1_nbit_stream #(.N(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .w0       (w0),
    .w0_valid (w0_valid),
    .w0_ready (w0_ready),
    .w1       (w1),
    .w1_valid (w1_valid),
    .w1_ready (w1_ready),
    .f        (f),
    .s        (s),
    .f_valid  (f_valid),
    .f_ready  (f_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: the output register is a queue of at most one word.
  typedef struct {
    logic [N-1:0] data;
    logic         src;
  } word_t;

  word_t m_slot[$];
  int    m_last;      // channel that won the last grant
  logic [N-1:0] m_f;  // value f shows (held after the slot drains)
  logic         m_s;

  task automatic model_reset();
    m_slot.delete();
    m_last = 1;
    m_f    = '0;
    m_s    = 1'b0;
  endtask

  // Which channel the rules say should be granted (-1 = none).
  function automatic int winner(input logic v0, input logic v1, input logic fr);
    bit room;
    room = (m_slot.size() == 0) || fr;
    if (!room) return -1;
    if (v0 && v1) begin
`ifdef MUX_RR_ARB_EN
      return (m_last == 0) ? 1 : 0;
`else
      return 0;
`endif
    end
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  // One clock: drive inputs, check readies mid-cycle, advance model on the
  // edge, check registered outputs just after it.
  task automatic step(input logic [N-1:0] a, input logic av,
                      input logic [N-1:0] b, input logic bv, input logic fr);
    int win;
    w0 = a; w0_valid = av; w1 = b; w1_valid = bv; f_ready = fr;
    #4;
    win = winner(av, bv, fr);
    check("w0_ready", 32'(w0_ready), 32'(win == 0));
    check("w1_ready", 32'(w1_ready), 32'(win == 1));
    @(posedge clk);
    if (m_slot.size() != 0 && fr) void'(m_slot.pop_front());
    if (win >= 0) begin
      word_t w;
      w.data = (win == 1) ? b : a;
      w.src  = (win == 1);
      m_slot.push_back(w);
      m_last = win;
      m_f = w.data;
      m_s = w.src;
    end
    #1;
    check("f_valid", 32'(f_valid), 32'(m_slot.size() != 0));
    if (m_slot.size() != 0) begin
      check("f", 32'(f), 32'(m_f));
      check("s", 32'(s), 32'(m_s));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_f_valid"},  32'(f_valid),  32'd0);
    check({tag, "_f"},        32'(f),        32'd0);
    check({tag, "_s"},        32'(s),        32'd0);
    check({tag, "_w0_ready"}, 32'(w0_ready), 32'd0);
    check({tag, "_w1_ready"}, 32'(w1_ready), 32'd0);
  endtask

  initial begin
    w0 = '0; w1 = '0; w0_valid = 1'b0; w1_valid = 1'b0; f_ready = 1'b0;
    reset = 1'b1;
    model_reset();
    // Valids high during reset must still see readies low.
    w0_valid = 1'b1; w1_valid = 1'b1; f_ready = 1'b1;
    #12;
    check_reset_outputs("rst");
    w0_valid = 1'b0; w1_valid = 1'b0;
    #5 reset = 1'b0;
    @(posedge clk); #1;

    // Single w0 word.
    step(4'd3, 1'b1, 4'd0, 1'b0, 1'b1);
    check("basic_f", 32'(f), 32'd3);

    // Continuous contention.
    for (int i = 0; i < 6; i++) step(4'd3, 1'b1, 4'd5, 1'b1, 1'b1);

    // Sink stalls for 5 cycles while FULL, then resumes.
    step(4'd3, 1'b1, 4'd0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(4'd3, 1'b1, 4'd5, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(4'd3, 1'b1, 4'd5, 1'b1, 1'b1);

    // Asynchronous reset while FULL, away from the clock edge.
    step(4'd7, 1'b1, 4'd9, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    #3 reset = 1'b0;
    @(posedge clk); #1;
    step(4'd3, 1'b1, 4'd5, 1'b1, 1'b1);
    check("post_rst_s", 32'(s), 32'd0);

    // Single w1 word.
    step(4'd0, 1'b0, 4'd9, 1'b1, 1'b1);
    check("w1_only_f", 32'(f), 32'd9);
    step(4'd0, 1'b0, 4'd0, 1'b0, 1'b1);

    // Randomised traffic.
    for (int i = 0; i < 400; i++)
      step(N'($urandom), 1'($urandom_range(0, 3) != 0),
           N'($urandom), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 3) != 0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mux_2x1_nbit_stream.md
DEMUX... no -- MUX_2X1_NBIT_STREAM -- requirements
Module: mux_2x1_nbit_stream

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 Parameter N, default 4: width of every data port.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 w0  input  N  channel-0 data.
REQ-006 w0_valid  input  1  w0 holds a word.
REQ-007 w0_ready  output  1  block accepts w0 this cycle.
REQ-008 w1  input  N  channel-1 data.
REQ-009 w1_valid  input  1  w1 holds a word.
REQ-010 w1_ready  output  1  block accepts w1 this cycle.
REQ-011 f  output  N  merged output data.
REQ-012 s  output  1  source tag of f: 0 = w0, 1 = w1.
REQ-013 f_valid  output  1  f and s hold a word.
REQ-014 f_ready  input  1  sink accepts f this cycle.

Function
REQ-015 Merges two valid/ready streams into one; the inverse of the 2x1 demux, which routes f to w0/w1 by s.
REQ-016 A transfer on any port occurs when valid and ready are both high on a rising clk edge.
REQ-017 Single-entry output register; state machine has two states, EMPTY (f_valid=0) and FULL (f_valid=1).
REQ-018 The output register can load when state is EMPTY, or when state is FULL and f_ready=1.
REQ-019 Grant: at most one of w0_ready/w1_ready is high in any cycle. A channel's ready is high only if that channel is granted, its valid is high, and the output register can load.
REQ-020 Arbitration is round-robin. With both valid, grant the channel not granted last. With one valid, grant that channel.
REQ-021 Accepted word appears on f, with s equal to its channel, one cycle after acceptance; latency is 1 clk.
REQ-022 Data is passed unmodified; all N bits are preserved.
REQ-023 EMPTY -> FULL on an input transfer.
REQ-024 FULL -> EMPTY on an output transfer with no input transfer.
REQ-025 FULL stays FULL on an output transfer plus a simultaneous input transfer, giving full throughput of one word per clk.
REQ-026 FULL stays FULL on no output transfer; f and s are held stable and both readies are low.
REQ-027 f and s are held stable while f_valid=1 and f_ready=0.
REQ-028 When neither input is valid, no grant is made and the last-granted pointer does not change.
REQ-029 The readies depend combinationally on f_ready, the valids and internal state only; no other combinational input-to-output path exists.

Reset
REQ-030 Reset asserted forces f_valid=0, f=0, s=0, state EMPTY and last-granted=1, so w0 wins the first contention. w0_ready and w1_ready are low while reset is high.
REQ-031 Reset asserted mid-operation discards any held word. No transfer completes on an edge where reset is high.

Configuration
REQ-032 Macro MUX_RR_ARB_EN controls arbitration.
REQ-033 With MUX_RR_ARB_EN defined: round-robin arbitration per REQ-020.
REQ-034 Without MUX_RR_ARB_EN: fixed priority. w0 always wins when both are valid, and the last-granted pointer is not implemented.

Verification
REQ-035 N=4, reset, then w0=3 with w0_valid=1, w1_valid=0, f_ready=1 -> next cycle f=3, s=0, f_valid=1.
REQ-036 Both valid continuously with w0=3, w1=5 and f_ready=1 -> f alternates 3/5 with s alternating 0/1 every clk, starting 3/0. Without MUX_RR_ARB_EN, f=3, s=0 every clk.
REQ-037 f_ready=0 for 5 cycles while FULL with f=3 -> f, s and f_valid are stable, w0_ready=w1_ready=0. On f_ready=1, the word transfers and the next word follows with no bubble.
REQ-038 Reset pulsed while FULL -> f_valid=0, f=0 and s=0 immediately, without waiting for clk. After release, the next contention grants w0.
REQ-039 Single valid w1=9 while w0_valid=0 -> w1_ready=1 and w0_ready=0; next cycle f=9, s=1.
